// File: rtl/oclib_reset_sequencer.sv
// Ordered per-stage reset release after power-on or an accepted req/ack request; outputs registered.
// Release latency is fixed by the Hold/StageGap/Post parameters; a request is ignored (no queueing) while busy.
module oclib_reset_sequencer #(
  parameter int Stages         = 3,
  parameter int HoldCycles     = 20,
  parameter int StageGapCycles = 4,
  parameter int PostCycles     = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              resetReq,
  output logic              resetAck,
  output logic [Stages-1:0] resetOut,
  output logic              busy,
  output logic              done
);

  localparam int MaxHG     = (HoldCycles > StageGapCycles) ? HoldCycles : StageGapCycles;
  localparam int MaxCycles = (MaxHG > PostCycles) ? MaxHG : PostCycles;
  localparam int CW        = $clog2(MaxCycles + 1);
  localparam int KW        = $clog2(Stages + 1);

  localparam logic [CW-1:0] HoldLast = CW'(HoldCycles - 1);
  localparam logic [CW-1:0] GapLast  = CW'(StageGapCycles - 1);
  localparam logic [CW-1:0] PostLast = CW'(PostCycles - 1);
  localparam logic [KW-1:0] LastK    = KW'(Stages - 1);

  if (Stages < 1 || HoldCycles < 1 || StageGapCycles < 1 || PostCycles < 1) begin : g_param_err
    $error("oclib_reset_sequencer: all parameters must be >= 1");
  end

  typedef enum logic [1:0] {ASSERT, RELEASE, POST, IDLE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [KW-1:0]     k, k_nxt;
  logic [Stages-1:0] out_nxt;
  logic              busy_nxt, ack_nxt, done_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ASSERT;
      cnt      <= '0;
      k        <= '0;
      resetOut <= '1;
      busy     <= 1'b1;
      resetAck <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      k        <= k_nxt;
      resetOut <= out_nxt;
      busy     <= busy_nxt;
      resetAck <= ack_nxt;
      done     <= done_nxt;
    end
  end

  // Shifting a zero in from bit 0 releases stages strictly in index order.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    k_nxt     = k;
    out_nxt   = resetOut;
    busy_nxt  = busy;
    ack_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ASSERT: begin
        out_nxt = '1;
        if (cnt == HoldLast) begin
          out_nxt   = {Stages{1'b1}} << 1;
          cnt_nxt   = '0;
          k_nxt     = KW'(1);
          state_nxt = (Stages > 1) ? RELEASE : POST;
        end
      end
      RELEASE: begin
        if (cnt == GapLast) begin
          out_nxt = resetOut << 1;
          cnt_nxt = '0;
          k_nxt   = k + 1'b1;
          if (k == LastK) state_nxt = POST;
        end
      end
      POST: begin
        if (cnt == PostLast) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      IDLE: begin
        cnt_nxt = cnt;
        out_nxt = '0;
        if (resetReq) begin
          out_nxt   = '1;
          busy_nxt  = 1'b1;
          ack_nxt   = 1'b1;
          cnt_nxt   = '0;
          k_nxt     = '0;
          state_nxt = ASSERT;
        end
      end
      default: state_nxt = ASSERT;
    endcase
  end

endmodule

// File: tb/tb_oclib_reset_sequencer.sv
// Bench for oclib_reset_sequencer: a 3-stage and a 1-stage instance share stimulus and are
// checked each cycle against a time-since-origin model, plus literal per-edge expectations.
module tb_oclib_reset_sequencer;

  localparam int S1 = 3, H1 = 4, G1 = 2, P1 = 3;
  localparam int S2 = 1, H2 = 1, G2 = 1, P2 = 1;
  localparam int T1 = H1 + (S1 - 1) * G1 + P1;
  localparam int T2 = H2 + (S2 - 1) * G2 + P2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, resetReq;
  logic       ack1, busy1, done1;
  logic [2:0] out1;
  logic       ack2, busy2, done2;
  logic [0:0] out2;

  oclib_reset_sequencer #(.Stages(S1), .HoldCycles(H1), .StageGapCycles(G1), .PostCycles(P1)) dut1 (
    .clock(clock), .reset(reset), .resetReq(resetReq), .resetAck(ack1),
    .resetOut(out1), .busy(busy1), .done(done1));

  oclib_reset_sequencer #(.Stages(S2), .HoldCycles(H2), .StageGapCycles(G2), .PostCycles(P2)) dut2 (
    .clock(clock), .reset(reset), .resetReq(resetReq), .resetAck(ack2),
    .resetOut(out2), .busy(busy2), .done(done2));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: n = edges since the last sequence origin (reset edge or accepted request).
  // Stage i is released once n reaches H + i*G; done fires at n == H + (S-1)*G + P.
  function automatic logic [2:0] m_out(input int n, input int s, input int h, input int g);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 0; i < s; i++) r[i] = !(n >= h + i * g);
    return r;
  endfunction

  int n1 = 0, n2 = 0;
  bit acc1 = 0, acc2 = 0, valid = 0;

  always @(posedge clock) begin
    if (reset === 1'b1) begin
      n1 = 0; acc1 = 0; n2 = 0; acc2 = 0; valid = 1;
    end else if (valid) begin
      if (n1 >= T1 && resetReq) begin n1 = 0; acc1 = 1; end
      else begin if (n1 <= T1) n1 = n1 + 1; acc1 = 0; end
      if (n2 >= T2 && resetReq) begin n2 = 0; acc2 = 1; end
      else begin if (n2 <= T2) n2 = n2 + 1; acc2 = 0; end
    end
  end

  always @(negedge clock) begin
    if (valid) begin
      chk("m1_out",  out1,  m_out(n1, S1, H1, G1));
      chk("m1_busy", busy1, n1 < T1);
      chk("m1_done", done1, n1 == T1);
      chk("m1_ack",  ack1,  acc1 && n1 == 0);
      chk("m2_out",  {2'b00, out2}, m_out(n2, S2, H2, G2));
      chk("m2_busy", busy2, n2 < T2);
      chk("m2_done", done2, n2 == T2);
      chk("m2_ack",  ack2,  acc2 && n2 == 0);
      chk("order1",  out1 & ~{1'b1, out1[2:1]}, 0);
      chk("done_ack1", done1 & ack1, 0);
      chk("done_ack2", done2 & ack2, 0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Literal 3-stage output after the r-th edge from an accepted request (r=0 is the accept edge).
  function automatic logic [2:0] lit_r(input int r);
    return (r < 4) ? 3'b111 : (r < 6) ? 3'b110 : (r < 8) ? 3'b100 : 3'b000;
  endfunction

  // Twelve edges E0..E11 after reset deasserts: releases after E3/E5/E7, done after E10.
  task automatic check_por(input string tag);
    for (int e = 0; e <= 11; e++) begin
      tick();
      chk({tag, "_out"},  out1,  lit_r(e + 1));
      chk({tag, "_done"}, done1, e == 10);
      chk({tag, "_busy"}, busy1, e < 10);
      chk({tag, "_ack"},  ack1,  0);
    end
  endtask

  initial begin
    reset = 1'b1;
    resetReq = 1'b0;

    // Power-on, plus the single-stage instance timing
    repeat (5) tick();
    chk("por_out", out1, 3'b111);
    chk("por_busy", busy1, 1);
    chk("por_out2", out2, 1);
    reset = 1'b0;
    for (int e = 0; e <= 11; e++) begin
      tick();
      chk("t1_out",  out1,  lit_r(e + 1));
      chk("t1_done", done1, e == 10);
      chk("t1_busy", busy1, e < 10);
      chk("t6_out",  out2,  0);
      chk("t6_done", done2, e == 1);
      chk("t6_busy", busy2, e < 1);
    end

    // Request in IDLE, dropped on ack
    resetReq = 1'b1;
    for (int r = 0; r <= 12; r++) begin
      tick();
      if (r == 0) begin
        chk("t2_ack", ack1, 1);
        resetReq = 1'b0;
      end else begin
        chk("t2_noack", ack1, 0);
      end
      chk("t2_out",  out1,  lit_r(r));
      chk("t2_done", done1, r == 11);
    end
    repeat (14) tick();
    chk("t2_single", busy1, 0);

    // Request pulsed while RELEASE is in progress
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 0; e <= 11; e++) begin
      tick();
      if (e == 3) resetReq = 1'b1;
      if (e == 5) resetReq = 1'b0;
      chk("t3_out",  out1,  lit_r(e + 1));
      chk("t3_done", done1, e == 10);
      chk("t3_ack",  ack1,  0);
    end
    repeat (4) tick();

    // Reset one edge after stage 0 releases
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("t4_pre_out", out1, 3'b110);
    reset = 1'b1;
    tick();
    chk("t4_rst_out", out1, 3'b111);
    chk("t4_rst_done", done1, 0);
    reset = 1'b0;
    check_por("t4");

    // Request held high: back-to-back sequences, ack one cycle after each done
    resetReq = 1'b1;
    for (int r = 0; r <= 25; r++) begin
      tick();
      chk("t5_ack",  ack1,  (r % 12) == 0);
      chk("t5_done", done1, (r % 12) == 11);
      chk("t5_out",  out1,  lit_r(r % 12));
    end
    resetReq = 1'b0;
    repeat (15) tick();
    chk("t5_end_busy", busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
